// File: rtl/uart_prog_loader.sv
// UART-driven instruction-ROM loader: receives a word-count header plus little-endian
// 32-bit words over 8N1 serial and drives the fetch stage's upg_* write port.
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 14,
    parameter int MAX_WORDS    = 16384,
    parameter int TIMEOUT_CLKS = 2**24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    input  logic              start_i,
    output logic              upg_rst_o,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              err_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, DONE, ERR} state_t;

    logic          rx_m, rx_s, rx_d;
    rx_state_t     rx_st, rx_st_nx;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_sh;
    logic          half_tick, bit_tick;
    logic          byte_vld, frame_err;

    state_t        state, state_nx;
    logic [7:0]    n_lo;
    logic [16:0]   n_words, n_full, word_cnt;
    logic [1:0]    byte_idx;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit, loading, start_hdr;

    // ---------------- serial receiver ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx_i;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign half_tick = (rx_cnt == CW'(CLKS_PER_BIT/2 - 1));
    assign bit_tick  = (rx_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_st <= R_IDLE;
        else      rx_st <= rx_st_nx;
    end

    always_comb begin
        rx_st_nx = rx_st;
        unique case (rx_st)
            R_IDLE:  if (rx_d && !rx_s) rx_st_nx = R_START;
            R_START: if (half_tick) rx_st_nx = rx_s ? R_IDLE : R_DATA;
            R_DATA:  if (bit_tick && bit_idx == 3'd7) rx_st_nx = R_STOP;
            R_STOP:  if (bit_tick) rx_st_nx = R_IDLE;
            default: rx_st_nx = R_IDLE;
        endcase
    end

    // Counter restarts on every state change, so the start-bit half period aligns later samples to bit centres.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_cnt    <= '0;
            bit_idx   <= '0;
            rx_sh     <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_vld <= 1'b0;
            if (rx_st == R_IDLE || rx_st_nx != rx_st || (rx_st == R_DATA && bit_tick))
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + CW'(1);
            if (rx_st == R_START) bit_idx <= '0;
            if (rx_st == R_DATA && bit_tick) begin
                rx_sh   <= {rx_s, rx_sh[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (rx_st == R_STOP && bit_tick) begin
                byte_vld  <= 1'b1;
                frame_err <= ~rx_s;
            end
        end
    end

    // ---------------- load controller ----------------
    assign loading   = (state == HDR0) || (state == HDR1) || (state == DATA);
    assign start_hdr = start_i && !loading;
    assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT_CLKS - 1));
    assign n_full    = {1'b0, rx_sh, n_lo};

    assign upg_rst_o  = (state == IDLE) || (state == DONE);
    assign upg_done_o = (state == DONE);
    assign err_o      = (state == ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE, ERR: if (start_i) state_nx = HDR0;
            HDR0: begin
                if (tmo_hit || (byte_vld && frame_err)) state_nx = ERR;
                else if (byte_vld)                      state_nx = HDR1;
            end
            HDR1: begin
                if (tmo_hit || (byte_vld && frame_err)) state_nx = ERR;
                else if (byte_vld) begin
                    if (n_full == '0)                    state_nx = DONE;
                    else if (n_full > 17'(MAX_WORDS))    state_nx = ERR;
                    else                                 state_nx = DATA;
                end
            end
            DATA: begin
                if (tmo_hit || (byte_vld && frame_err))                state_nx = ERR;
                else if (upg_wen_o && (word_cnt + 17'd1 == n_words))   state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upg_wen_o <= 1'b0;
            upg_adr_o <= '0;
            upg_dat_o <= '0;
            n_lo      <= '0;
            n_words   <= '0;
            word_cnt  <= '0;
            byte_idx  <= '0;
            tmo_cnt   <= '0;
        end else begin
            upg_wen_o <= 1'b0;
            if (start_hdr) begin
                upg_adr_o <= '0;
                byte_idx  <= '0;
                word_cnt  <= '0;
                tmo_cnt   <= '0;
            end else if (loading) begin
                tmo_cnt <= byte_vld ? '0 : tmo_cnt + TW'(1);
                if (state == HDR0 && byte_vld) n_lo    <= rx_sh;
                if (state == HDR1 && byte_vld) n_words <= n_full;
                // A byte that triggers ERR never reaches the data register, so partial words stay unwritten.
                if (state == DATA && state_nx == DATA && byte_vld) begin
                    upg_dat_o[{byte_idx, 3'b000} +: 8] <= rx_sh;
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) upg_wen_o <= 1'b1;
                end
                if (upg_wen_o) begin
                    upg_adr_o <= upg_adr_o + ADDR_W'(1);
                    word_cnt  <= word_cnt + 17'd1;
                end
            end
        end
    end
endmodule
